// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 parallel-bus reader.
package ad7606_pkg;

   localparam int AD7606_DB_W   = 16;
   localparam int AD7606_MAX_CH = 8;

   localparam int ERR_BUSY_TO  = 0;
   localparam int ERR_FRSTDATA = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONV_LO,
      ST_WAIT_BUSY_HI,
      ST_WAIT_BUSY_LO,
      ST_RD_LO,
      ST_RD_HI,
      ST_FINISH
   } state_t;

endpackage

// File: rtl/ad7606_reader_sync2.sv
// Two-flop synchroniser for the ADC's asynchronous status pins.
module sync2 (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d,
   output logic q
);

   logic meta_reg;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         meta_reg <= 1'b0;
         q        <= 1'b0;
      end else begin
         meta_reg <= d;
         q        <= meta_reg;
      end
   end

endmodule

// File: rtl/ad7606_reader.sv
// Host-side AD7606 controller: CONVST pulse, BUSY handshake, CS/RD word readout
// with FRSTDATA alignment check; one shared phase counter times every state.
module ad7606_reader
   import ad7606_pkg::*;
#(
   parameter int NUM_CH        = 8,
   parameter int CONVST_LO_CYC = 4,
   parameter int RD_LO_CYC     = 4,
   parameter int RD_HI_CYC     = 2,
   parameter int BUSY_RISE_TO  = 16,
   parameter int BUSY_FALL_TO  = 1024
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   start_i,
   input  logic [2:0]             os_cfg_i,
   output logic [2:0]             os_o,
   output logic                   convstw_o,
   output logic                   cs_o,
   output logic                   rd_o,
   input  logic [AD7606_DB_W-1:0] db_i,
   input  logic                   busy_i,
   input  logic                   frstdata_i,
   output logic [AD7606_DB_W-1:0] sample_o,
   output logic [2:0]             ch_o,
   output logic                   valid_o,
   output logic                   done_o,
   output logic                   idle_o,
   output logic [1:0]             err_o
);

   localparam logic [15:0] CONV_LAST = 16'(CONVST_LO_CYC - 1);
   localparam logic [15:0] RDLO_LAST = 16'(RD_LO_CYC - 1);
   localparam logic [15:0] RDHI_LAST = 16'(RD_HI_CYC - 1);
   localparam logic [15:0] RISE_LAST = 16'(BUSY_RISE_TO - 1);
   localparam logic [15:0] FALL_LAST = 16'(BUSY_FALL_TO - 1);
   localparam logic [2:0]  CH_LAST   = 3'(NUM_CH - 1);

   logic busy_s;
   logic frst_s;

   sync2 u_sync_busy (.clk_i(clk_i), .reset_i(reset_i), .d(busy_i),     .q(busy_s));
   sync2 u_sync_frst (.clk_i(clk_i), .reset_i(reset_i), .d(frstdata_i), .q(frst_s));

   state_t                   state_reg,  state_next;
   logic [15:0]              cnt_reg,    cnt_next;
   logic [2:0]               ch_reg,     ch_next;
   logic                     convst_reg, convst_next;
   logic                     cs_reg,     cs_next;
   logic                     rd_reg,     rd_next;
   logic [2:0]               os_reg,     os_next;
   logic [AD7606_DB_W-1:0]   sample_reg, sample_next;
   logic [2:0]               chout_reg,  chout_next;
   logic                     valid_reg,  valid_next;
   logic                     done_reg,   done_next;
   logic [1:0]               err_reg,    err_next;
   logic [15:0]              cnt_inc;

   // Saturating so a stuck timeout can never wrap back into range.
   assign cnt_inc = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         ch_reg     <= '0;
         convst_reg <= 1'b1;
         cs_reg     <= 1'b1;
         rd_reg     <= 1'b1;
         os_reg     <= '0;
         sample_reg <= '0;
         chout_reg  <= '0;
         valid_reg  <= 1'b0;
         done_reg   <= 1'b0;
         err_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         ch_reg     <= ch_next;
         convst_reg <= convst_next;
         cs_reg     <= cs_next;
         rd_reg     <= rd_next;
         os_reg     <= os_next;
         sample_reg <= sample_next;
         chout_reg  <= chout_next;
         valid_reg  <= valid_next;
         done_reg   <= done_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      ch_next     = ch_reg;
      convst_next = convst_reg;
      cs_next     = cs_reg;
      rd_next     = rd_reg;
      os_next     = os_reg;
      sample_next = sample_reg;
      chout_next  = chout_reg;
      valid_next  = 1'b0;
      done_next   = 1'b0;
      err_next    = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               os_next     = os_cfg_i;
               err_next    = '0;
               convst_next = 1'b0;
               cnt_next    = '0;
               state_next  = ST_CONV_LO;
            end
         end
         ST_CONV_LO: begin
            if (cnt_reg == CONV_LAST) begin
               convst_next = 1'b1;
               cnt_next    = '0;
               state_next  = ST_WAIT_BUSY_HI;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         ST_WAIT_BUSY_HI: begin
            if (busy_s) begin
               cnt_next   = '0;
               state_next = ST_WAIT_BUSY_LO;
            end else if (cnt_reg >= RISE_LAST) begin
               err_next[ERR_BUSY_TO] = 1'b1;
               done_next             = 1'b1;
               state_next            = ST_FINISH;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         ST_WAIT_BUSY_LO: begin
            if (!busy_s) begin
               cs_next    = 1'b0;
               rd_next    = 1'b0;
               ch_next    = '0;
               cnt_next   = '0;
               state_next = ST_RD_LO;
            end else if (cnt_reg >= FALL_LAST) begin
               err_next[ERR_BUSY_TO] = 1'b1;
               done_next             = 1'b1;
               state_next            = ST_FINISH;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         ST_RD_LO: begin
            if (cnt_reg == RDLO_LAST) begin
               sample_next = db_i;
               chout_next  = ch_reg;
               valid_next  = 1'b1;
               // FRSTDATA must be high exactly while channel 0 is on the bus.
               if (frst_s != (ch_reg == 3'd0))
                  err_next[ERR_FRSTDATA] = 1'b1;
               rd_next    = 1'b1;
               cnt_next   = '0;
               state_next = ST_RD_HI;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         ST_RD_HI: begin
            if (cnt_reg == RDHI_LAST) begin
               cnt_next = '0;
               if (ch_reg == CH_LAST) begin
                  cs_next    = 1'b1;
                  done_next  = 1'b1;
                  state_next = ST_FINISH;
               end else begin
                  ch_next    = ch_reg + 3'd1;
                  rd_next    = 1'b0;
                  state_next = ST_RD_LO;
               end
            end else begin
               cnt_next = cnt_inc;
            end
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   assign os_o      = os_reg;
   assign convstw_o = convst_reg;
   assign cs_o      = cs_reg;
   assign rd_o      = rd_reg;
   assign sample_o  = sample_reg;
   assign ch_o      = chout_reg;
   assign valid_o   = valid_reg;
   assign done_o    = done_reg;
   assign idle_o    = (state_reg == ST_IDLE);
   assign err_o     = err_reg;

endmodule

// File: tb/tb_ad7606_reader.sv
// Directed bench for ad7606_reader: an 8-channel and a 4-channel instance, each
// driven by a small AD7606 behavioural model (BUSY +45 ns after CONVST, 4 us wide).
module tb_ad7606_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   checks   = 0;
   int   failures = 0;

   bit          busy_en   = 1'b1;
   bit          frst_bad  = 1'b0;
   logic [15:0] data_base = 16'd0;

   // ---------------- 8-channel instance ----------------
   logic        start0 = 1'b0;
   logic [2:0]  os_cfg0 = 3'd0, os0, ch0;
   logic        convst0, cs0, rd0, valid0, done0, idle0;
   logic [15:0] db0 = 16'd0, smp0;
   logic        busy0 = 1'b0, frst0 = 1'b0;
   logic [1:0]  err0;
   int          adc_ch0 = 0;

   ad7606_reader #(.NUM_CH(8)) u_dut8 (
      .clk_i(clk), .reset_i(rst), .start_i(start0), .os_cfg_i(os_cfg0), .os_o(os0),
      .convstw_o(convst0), .cs_o(cs0), .rd_o(rd0), .db_i(db0), .busy_i(busy0),
      .frstdata_i(frst0), .sample_o(smp0), .ch_o(ch0), .valid_o(valid0),
      .done_o(done0), .idle_o(idle0), .err_o(err0)
   );

   always @(posedge convst0) begin
      if (busy_en) begin
         #45   busy0 = 1'b1;
         #4000 busy0 = 1'b0;
      end
   end

   always @(negedge rd0 or negedge busy0) begin
      if (rd0 === 1'b1) begin
         adc_ch0 = 0;
      end else begin
         db0     = data_base + 16'(adc_ch0) + 16'd1;
         frst0   = (adc_ch0 == 0) && !frst_bad;
         adc_ch0 = adc_ch0 + 1;
      end
   end

   int          vcnt0 = 0, done_cnt0 = 0, conv_lo0 = 0, rd_falls0 = 0;
   logic        rd_prev0 = 1'b1;
   logic [2:0]  rec_ch0  [64];
   logic [15:0] rec_smp0 [64];

   always @(negedge clk) begin
      if (valid0 === 1'b1) begin
         if (vcnt0 < 64) begin
            rec_ch0[vcnt0]  = ch0;
            rec_smp0[vcnt0] = smp0;
         end
         vcnt0 = vcnt0 + 1;
      end
      if (done0 === 1'b1)   done_cnt0 = done_cnt0 + 1;
      if (convst0 === 1'b0) conv_lo0  = conv_lo0 + 1;
      if (rd_prev0 === 1'b1 && rd0 === 1'b0) rd_falls0 = rd_falls0 + 1;
      rd_prev0 = rd0;
   end

   // ---------------- 4-channel instance ----------------
   logic        start1 = 1'b0;
   logic [2:0]  os_cfg1 = 3'd0, os1, ch1;
   logic        convst1, cs1, rd1, valid1, done1, idle1;
   logic [15:0] db1 = 16'd0, smp1;
   logic        busy1 = 1'b0, frst1 = 1'b0;
   logic [1:0]  err1;
   int          adc_ch1 = 0;

   ad7606_reader #(.NUM_CH(4)) u_dut4 (
      .clk_i(clk), .reset_i(rst), .start_i(start1), .os_cfg_i(os_cfg1), .os_o(os1),
      .convstw_o(convst1), .cs_o(cs1), .rd_o(rd1), .db_i(db1), .busy_i(busy1),
      .frstdata_i(frst1), .sample_o(smp1), .ch_o(ch1), .valid_o(valid1),
      .done_o(done1), .idle_o(idle1), .err_o(err1)
   );

   always @(posedge convst1) begin
      #45   busy1 = 1'b1;
      #4000 busy1 = 1'b0;
   end

   always @(negedge rd1 or negedge busy1) begin
      if (rd1 === 1'b1) begin
         adc_ch1 = 0;
      end else begin
         db1     = data_base + 16'(adc_ch1) + 16'd1;
         frst1   = (adc_ch1 == 0);
         adc_ch1 = adc_ch1 + 1;
      end
   end

   int          vcnt1 = 0, done_cnt1 = 0;
   logic [2:0]  rec_ch1  [16];
   logic [15:0] rec_smp1 [16];

   always @(negedge clk) begin
      if (valid1 === 1'b1) begin
         if (vcnt1 < 16) begin
            rec_ch1[vcnt1]  = ch1;
            rec_smp1[vcnt1] = smp1;
         end
         vcnt1 = vcnt1 + 1;
      end
      if (done1 === 1'b1) done_cnt1 = done_cnt1 + 1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start0(input logic [2:0] os);
      @(negedge clk);
      os_cfg0 = os;
      start0  = 1'b1;
      @(negedge clk);
      start0  = 1'b0;
   endtask

   // n = number of clock edges after the accepted start edge when done_o was seen
   task automatic wait_done0(input int budget, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         @(negedge clk);
         n = n + 1;
         if (done0 === 1'b1) ok = 1'b1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({convst0, cs0, rd0, idle0} !== 4'b1111) begin
         failures++;
         $display("FAIL reset_pins: got convst/cs/rd/idle=%b want 1111", {convst0, cs0, rd0, idle0});
      end
      checks++;
      if ({os0, ch0} !== 6'd0 || smp0 !== 16'd0) begin
         failures++;
         $display("FAIL reset_data: got os=%b ch=%0d sample=%h want 0", os0, ch0, smp0);
      end
      checks++;
      if ({valid0, done0, err0} !== 4'd0) begin
         failures++;
         $display("FAIL reset_strobes: got valid/done/err=%b want 0000", {valid0, done0, err0});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_normal;
      int n; bit ok; int v0, d0, c0;
      data_base = 16'd0;
      v0 = vcnt0; d0 = done_cnt0; c0 = conv_lo0;
      pulse_start0(3'b101);
      wait_done0(1000, n, ok);
      checks++;
      if (!ok || n < 440 || n > 480) begin
         failures++;
         $display("FAIL normal_done: got ok=%0d cycles=%0d want ok=1 cycles 440..480", ok, n);
      end
      checks++;
      if (vcnt0 - v0 !== 8 || conv_lo0 - c0 !== 4) begin
         failures++;
         $display("FAIL normal_counts: got valids=%0d convst_lo=%0d want 8 and 4", vcnt0 - v0, conv_lo0 - c0);
      end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (rec_ch0[v0+k] !== 3'(k) || rec_smp0[v0+k] !== 16'(k + 1)) begin
            failures++;
            $display("FAIL normal_word%0d: got ch=%0d sample=%h want ch=%0d sample=%h",
                     k, rec_ch0[v0+k], rec_smp0[v0+k], k, k + 1);
         end
      end
      checks++;
      if (err0 !== 2'b00 || os0 !== 3'b101 || cs0 !== 1'b1) begin
         failures++;
         $display("FAIL normal_status: got err=%b os=%b cs=%b want 00 101 1", err0, os0, cs0);
      end
      @(negedge clk);
      checks++;
      if (idle0 !== 1'b1 || done0 !== 1'b0 || done_cnt0 - d0 !== 1) begin
         failures++;
         $display("FAIL normal_idle: got idle=%b done=%b dones=%0d want 1 0 1", idle0, done0, done_cnt0 - d0);
      end
      $display("test_normal done cycles=%0d", n);
   endtask

   task automatic test_busy_timeout;
      int n; bit ok; int v0, r0;
      busy_en = 1'b0;
      v0 = vcnt0; r0 = rd_falls0;
      pulse_start0(3'b000);
      wait_done0(200, n, ok);
      checks++;
      if (!ok || n !== 20 || err0 !== 2'b01) begin
         failures++;
         $display("FAIL busy_timeout: got ok=%0d cycles=%0d err=%b want ok=1 cycles=20 err=01", ok, n, err0);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (rd_falls0 - r0 !== 0 || vcnt0 - v0 !== 0 || err0 !== 2'b01) begin
         failures++;
         $display("FAIL timeout_no_read: got rd_falls=%0d valids=%0d err=%b want 0 0 01",
                  rd_falls0 - r0, vcnt0 - v0, err0);
      end
      busy_en = 1'b1;
      $display("test_busy_timeout done");
   endtask

   task automatic test_frstdata;
      int n; bit ok; int v0;
      frst_bad  = 1'b1;
      data_base = 16'h0010;
      v0 = vcnt0;
      pulse_start0(3'b000);
      wait_done0(1000, n, ok);
      checks++;
      if (!ok || vcnt0 - v0 !== 8 || err0 !== 2'b10) begin
         failures++;
         $display("FAIL frstdata: got ok=%0d valids=%0d err=%b want 1 8 10", ok, vcnt0 - v0, err0);
      end
      checks++;
      if (rec_smp0[v0+7] !== 16'h0018 || rec_ch0[v0+7] !== 3'd7) begin
         failures++;
         $display("FAIL frstdata_last: got ch=%0d sample=%h want 7 0018", rec_ch0[v0+7], rec_smp0[v0+7]);
      end
      frst_bad = 1'b0;
      @(negedge clk);
      $display("test_frstdata done");
   endtask

   task automatic test_back_to_back;
      int n; bit ok; int v0, d0, c0, w;
      data_base = 16'h0020;
      v0 = vcnt0; d0 = done_cnt0; c0 = conv_lo0;
      pulse_start0(3'b000);
      w = 0;
      while (cs0 !== 1'b0 && w < 600) begin
         @(negedge clk);
         w++;
      end
      checks++;
      if (cs0 !== 1'b0) begin
         failures++;
         $display("FAIL b2b_cs: got cs=%b want 0 within 600 cycles", cs0);
      end
      for (int k = 0; k < 3; k++) begin
         start0 = 1'b1;
         @(negedge clk);
         start0 = 1'b0;
         repeat (5) @(negedge clk);
      end
      wait_done0(1000, n, ok);
      repeat (30) @(negedge clk);
      checks++;
      if (!ok || vcnt0 - v0 !== 8 || done_cnt0 - d0 !== 1 || conv_lo0 - c0 !== 4 || idle0 !== 1'b1) begin
         failures++;
         $display("FAIL b2b: got ok=%0d valids=%0d dones=%0d convst_lo=%0d idle=%b want 1 8 1 4 1",
                  ok, vcnt0 - v0, done_cnt0 - d0, conv_lo0 - c0, idle0);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid;
      int n; bit ok; int v0, r0, w;
      data_base = 16'h0030;
      v0 = vcnt0; r0 = rd_falls0;
      pulse_start0(3'b000);
      w = 0;
      while (rd_falls0 - r0 < 4 && w < 700) begin
         @(negedge clk);
         w++;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({cs0, rd0, idle0, convst0, valid0} !== 5'b11110 || vcnt0 - v0 !== 3) begin
         failures++;
         $display("FAIL reset_mid: got cs/rd/idle/convst/valid=%b valids=%0d want 11110 3",
                  {cs0, rd0, idle0, convst0, valid0}, vcnt0 - v0);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      data_base = 16'h0040;
      v0 = vcnt0;
      pulse_start0(3'b000);
      wait_done0(1000, n, ok);
      checks++;
      if (!ok || vcnt0 - v0 !== 8 || err0 !== 2'b00) begin
         failures++;
         $display("FAIL reset_recover: got ok=%0d valids=%0d err=%b want 1 8 00", ok, vcnt0 - v0, err0);
      end
      for (int k = 0; k < 8; k += 7) begin
         checks++;
         if (rec_ch0[v0+k] !== 3'(k) || rec_smp0[v0+k] !== 16'h0040 + 16'(k + 1)) begin
            failures++;
            $display("FAIL reset_recover_word%0d: got ch=%0d sample=%h want %0d %h",
                     k, rec_ch0[v0+k], rec_smp0[v0+k], k, 16'h0040 + 16'(k + 1));
         end
      end
      @(negedge clk);
      $display("test_reset_mid done");
   endtask

   task automatic test_num_ch4;
      int n; int v1, d1;
      bit ok;
      data_base = 16'h0200;
      v1 = vcnt1; d1 = done_cnt1;
      @(negedge clk);
      os_cfg1 = 3'b010;
      start1  = 1'b1;
      @(negedge clk);
      start1  = 1'b0;
      n = 0; ok = 1'b0;
      while (n < 1000 && !ok) begin
         @(negedge clk);
         n++;
         if (done1 === 1'b1) ok = 1'b1;
      end
      repeat (5) @(negedge clk);
      checks++;
      if (!ok || os1 !== 3'b010 || vcnt1 - v1 !== 4 || done_cnt1 - d1 !== 1 || err1 !== 2'b00) begin
         failures++;
         $display("FAIL num_ch4: got ok=%0d os=%b valids=%0d dones=%0d err=%b want 1 010 4 1 00",
                  ok, os1, vcnt1 - v1, done_cnt1 - d1, err1);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rec_ch1[v1+k] !== 3'(k) || rec_smp1[v1+k] !== 16'h0200 + 16'(k + 1)) begin
            failures++;
            $display("FAIL num_ch4_word%0d: got ch=%0d sample=%h want %0d %h",
                     k, rec_ch1[v1+k], rec_smp1[v1+k], k, 16'h0200 + 16'(k + 1));
         end
      end
      $display("test_num_ch4 done");
   endtask

   initial begin
      rst = 1'b1;
      test_reset();
      test_normal();
      test_busy_timeout();
      test_frstdata();
      test_back_to_back();
      test_reset_mid();
      test_num_ch4();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
